edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Multi-channel falling-edge event controller. Each raw input is synchronised and its falling edges are latched as pending events. A round-robin arbiter then presents the events one at a time to a single downstream consumer over a valid/ready handshake. It sits between asynchronous strobe lines and the shared event-handling logic, so that several edge sources can share one consumer.

## Interface
- N_CH, 4, number of input channels (2..16)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- din  in  N_CH  raw asynchronous inputs, idle high
- enable  in  N_CH  per-channel enable mask, synchronous to clk
- evt_valid  out  1  event offered to consumer
- evt_ready  in  1  consumer accepts event
- evt_ch  out  $clog2(N_CH)  channel index of offered event
- pending  out  N_CH  latched, not-yet-accepted events
- ovf  out  N_CH  sticky overflow flags (only with EDGE_ARB_OVF_EN)
- ovf_clr  in  N_CH  per-bit overflow clear pulse (only with EDGE_ARB_OVF_EN)

## Operation
- Per channel: synchroniser chain; s = last stage; s_d = s delayed one clk; fall = s_d & ~s.
- Synchroniser and s_d flops reset to 1, so release of reset with din low produces no event.
- pending[i] is set on fall[i] & enable[i]. It is cleared on handshake of channel i, or when enable[i] = 0.
- When the same edge causes both a set and a clear in one cycle, the set wins. A new edge during acceptance of that channel keeps the bit at 1.
- FSM state IDLE:
  - if |pending, grant the first pending channel at or after rr_ptr (wrapping N_CH-1 -> 0);
  - register that channel into evt_ch, set evt_valid = 1, go to OFFER.
- FSM state OFFER:
  - evt_valid and evt_ch are held stable until evt_valid & evt_ready;
  - on handshake: clear pending[evt_ch], set rr_ptr = (evt_ch + 1) mod N_CH, set evt_valid = 0, go to IDLE.
- Disabling a channel while it is being offered does not withdraw the offer. Valid never drops without a handshake.
- Output reset values: evt_valid = 0, evt_ch = 0, pending = 0, ovf = 0. rr_ptr also resets to 0.
- Reset asserted mid-OFFER: all state clears immediately and the FSM returns to IDLE. The consumer must discard any partially seen offer.

## Timing
- din first sampled low at edge T -> pending[i] = 1 after edge T+SYNC_STAGES.
- evt_valid = 1 after edge T+SYNC_STAGES+1, provided the FSM is in IDLE.
- Handshake on edge H -> evt_valid = 0 after H. The next offer, if any is pending, appears after H+1.
- Peak throughput is one event per 2 clocks.
- evt_ready may be held high permanently. Its value is ignored while evt_valid = 0.
- din must stay at each level for at least 2 clocks. Shorter pulses may be missed.

## Configuration
- EDGE_ARB_OVF_EN defined:
  - ovf and ovf_clr ports exist;
  - ovf[i] is set when fall[i] & enable[i] & pending[i] and pending[i] is not being cleared in the same cycle;
  - ovf[i] is cleared by ovf_clr[i]; set wins over clear.
- Not defined: neither port exists and repeated edges merge silently into one pending event.

## Structure
- Shared package edge_arb_pkg holds:
  - the FSM state enum (IDLE, OFFER);
  - the channel index width function;
  - default constants for N_CH and SYNC_STAGES.
- One sub-module, edge_capture_ch: synchroniser, s_d, fall output and the pending bit for one channel. The ovf bit is included when the macro is set. It is instantiated N_CH times with a generate loop.
- Round-robin selection and the FSM stay in the top module.

## Test plan
- Reset with all din = 0, then release rst and hold din low: pending stays 0 and evt_valid stays 0 for 20 clocks.
- Ch2 falls while evt_ready = 1, N_CH = 4, SYNC_STAGES = 2: evt_valid = 1 with evt_ch = 2 exactly 3 clocks after the first low sample. pending = 0 after the handshake.
- Ch0, ch1 and ch3 fall in the same cycle, with evt_ready held low for 5 clocks and then held high:
  - evt_ch stays 0 during the stall;
  - events are then accepted in order 0, 1, 3, with evt_valid low for one clock between them.
- rr_ptr = 2 (after serving ch1), then ch0 and ch3 are pending: ch3 is granted before ch0, confirming wrap-around.
- Ch1 offered, enable[1] deasserted, then evt_ready pulsed: the offer persists and is accepted with evt_ch = 1. A later ch1 edge while disabled produces no event.
- With EDGE_ARB_OVF_EN: two ch0 falls while evt_ready = 0 give ovf[0] = 1. A single ovf_clr[0] pulse returns it to 0. Only one ch0 event is delivered.

Source files
------------

// File: rtl/edge_arb_pkg.sv
// +------------------------------------------------------------------+
// | edge_arb_pkg : shared types and defaults for edge_event_arbiter  |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
`default_nettype none

package edge_arb_pkg;

  localparam int c_N_CH_DEFAULT        = 4;
  localparam int c_SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_event_arbiter_if.sv
// +------------------------------------------------------------------+
// | edge_event_arbiter_if : event offer valid/ready handshake        |
// | Revision              : 1.0                                      |
// +------------------------------------------------------------------+
`default_nettype none

interface edge_event_arbiter_if
  import edge_arb_pkg::*;
#(
  parameter int N_CH = c_N_CH_DEFAULT
);

  logic                      evt_valid;
  logic                      evt_ready;
  logic [ch_idx_w(N_CH)-1:0] evt_ch;

  modport master (output evt_valid, output evt_ch, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_ch, output evt_ready);

endinterface

`default_nettype wire

// File: rtl/edge_capture_ch.sv
// +------------------------------------------------------------------+
// | edge_capture_ch : synchroniser, falling-edge detect, pending bit |
// | Optional sticky overflow bit with EDGE_ARB_OVF_EN                |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
`default_nettype none

module edge_capture_ch
  import edge_arb_pkg::*;
#(
  parameter int SYNC_STAGES = c_SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic enable,
  input  logic clr,
`ifdef EDGE_ARB_OVF_EN
  input  logic ovf_clr,
  output logic ovf,
`endif
  output logic pending
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   r_s_d;
  logic                   r_pending;
  logic                   w_s;
  logic                   w_fall;
  logic                   w_set;

  // r_fill keeps edges masked until the chain and s_d hold real samples,
  // so a line that is already low when reset releases is not an event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '1;
      r_s_d  <= 1'b1;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_s_d  <= w_s;
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_fall = r_s_d & ~w_s & r_fill[SYNC_STAGES];
  assign w_set  = w_fall & enable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
    end else if (w_set) begin
      r_pending <= 1'b1;
    end else if (clr || !enable) begin
      r_pending <= 1'b0;
    end
  end

  assign pending = r_pending;

`ifdef EDGE_ARB_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= (w_set & r_pending & ~clr) | (r_ovf & ~ovf_clr);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: rtl/edge_event_arbiter.sv
// +------------------------------------------------------------------+
// | edge_event_arbiter : falling-edge events, round-robin offer      |
// | Optional overflow flags with EDGE_ARB_OVF_EN                     |
// | Revision           : 1.0                                         |
// +------------------------------------------------------------------+
`default_nettype none

module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH        = c_N_CH_DEFAULT,
  parameter int SYNC_STAGES = c_SYNC_STAGES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      din,
  input  logic [N_CH-1:0]      enable,
`ifdef EDGE_ARB_OVF_EN
  input  logic [N_CH-1:0]      ovf_clr,
  output logic [N_CH-1:0]      ovf,
`endif
  output logic [N_CH-1:0]      pending,
  edge_event_arbiter_if.master evt
);

  localparam int c_CW = ch_idx_w(N_CH);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic            r_evt_valid;
  logic            w_evt_valid_nxt;
  logic [c_CW-1:0] r_evt_ch;
  logic [c_CW-1:0] w_evt_ch_nxt;
  logic [c_CW-1:0] r_rr_ptr;
  logic [c_CW-1:0] w_rr_ptr_nxt;
  logic [c_CW-1:0] w_grant_ch;
  logic [c_CW-1:0] w_idx;
  logic            w_grant_found;
  logic            w_hs;
  logic [N_CH-1:0] w_clr;

  assign w_hs = r_evt_valid & evt.evt_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_clr[i] = w_hs && (r_evt_ch == c_CW'(i));

    edge_capture_ch #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_cap (
      .clk     (clk),
      .rst     (rst),
      .din     (din[i]),
      .enable  (enable[i]),
      .clr     (w_clr[i]),
`ifdef EDGE_ARB_OVF_EN
      .ovf_clr (ovf_clr[i]),
      .ovf     (ovf[i]),
`endif
      .pending (pending[i])
    );
  end

  // First pending channel at or after rr_ptr, wrapping to 0.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_ch    = '0;
    w_idx         = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_idx = c_CW'((int'(r_rr_ptr) + k) % N_CH);
      if (!w_grant_found && pending[w_idx]) begin
        w_grant_found = 1'b1;
        w_grant_ch    = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_evt_valid <= w_evt_valid_nxt;
      r_evt_ch    <= w_evt_ch_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_evt_valid_nxt = r_evt_valid;
    w_evt_ch_nxt    = r_evt_ch;
    w_rr_ptr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_grant_found) begin
          w_evt_ch_nxt    = w_grant_ch;
          w_evt_valid_nxt = 1'b1;
          w_state_nxt     = OFFER;
        end
      end
      OFFER: begin
        if (w_hs) begin
          w_evt_valid_nxt = 1'b0;
          w_rr_ptr_nxt    = (r_evt_ch == c_CW'(N_CH - 1)) ? '0 : r_evt_ch + 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_evt_valid_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  assign evt.evt_valid = r_evt_valid;
  assign evt.evt_ch    = r_evt_ch;

endmodule

`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
// +------------------------------------------------------------------+
// | tb_edge_event_arbiter : directed self-checking bench             |
// | Revision              : 1.0                                      |
// +------------------------------------------------------------------+
`default_nettype none

module tb_edge_event_arbiter;
  import edge_arb_pkg::*;

  localparam int N_CH        = 4;
  localparam int SYNC_STAGES = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] din;
  logic [N_CH-1:0] enable;
  logic [N_CH-1:0] pending;
`ifdef EDGE_ARB_OVF_EN
  logic [N_CH-1:0] ovf;
  logic [N_CH-1:0] ovf_clr;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  edge_event_arbiter_if #(.N_CH(N_CH)) evt_if ();

  always #5 clk = ~clk;

  edge_event_arbiter #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .enable  (enable),
`ifdef EDGE_ARB_OVF_EN
    .ovf_clr (ovf_clr),
    .ovf     (ovf),
`endif
    .pending (pending),
    .evt     (evt_if.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    din = '0;
    enable = '1;
    evt_if.evt_ready = 1'b0;
`ifdef EDGE_ARB_OVF_EN
    ovf_clr = '0;
`endif
    repeat (3) tick();
    n_cmp++; if (pending !== 4'h0) begin n_fail++; $display("FAIL rst_pending got %h want 0", pending); end
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_ch !== 2'd0) begin n_fail++; $display("FAIL rst_ch got %0d want 0", evt_if.evt_ch); end
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if (pending !== 4'h0 || evt_if.evt_valid !== 1'b0) begin
        n_fail++; $display("FAIL low_after_rst cyc %0d got pend %h valid %b want 0 0", c, pending, evt_if.evt_valid);
      end
    end
    din = '1;
    repeat (4) tick();
    n_cmp++; if (pending !== 4'h0 || evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rise_no_evt got pend %h valid %b want 0 0", pending, evt_if.evt_valid); end
  endtask

  task automatic test_single();
    evt_if.evt_ready = 1'b1;
    din[2] = 1'b0;
    repeat (3) tick();
    n_cmp++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL single_pend got %b want 0100", pending); end
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", evt_if.evt_valid); end
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd2) begin n_fail++; $display("FAIL single_offer got v%b ch%0d want v1 ch2", evt_if.evt_valid, evt_if.evt_ch); end
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b0 || pending !== 4'h0) begin n_fail++; $display("FAIL single_done got v%b pend %b want v0 0000", evt_if.evt_valid, pending); end
    din[2] = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_offer();
    evt_if.evt_ready = 1'b0;
    din[3] = 1'b0;
    repeat (4) tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd3) begin n_fail++; $display("FAIL midrst_offer got v%b ch%0d want v1 ch3", evt_if.evt_valid, evt_if.evt_ch); end
    rst = 1'b0;
    din[3] = 1'b1;
    #1;
    n_cmp++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_ch !== 2'd0 || pending !== 4'h0) begin
      n_fail++; $display("FAIL midrst_clear got v%b ch%0d pend %b want v0 ch0 0000", evt_if.evt_valid, evt_if.evt_ch, pending);
    end
    tick();
    rst = 1'b1;
    repeat (4) tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b0 || pending !== 4'h0) begin n_fail++; $display("FAIL midrst_quiet got v%b pend %b want v0 0000", evt_if.evt_valid, pending); end
  endtask

  task automatic test_stall_order();
    evt_if.evt_ready = 1'b0;
    din = 4'b0100;
    repeat (4) tick();
    n_cmp++; if (pending !== 4'b1011) begin n_fail++; $display("FAIL stall_pend got %b want 1011", pending); end
    n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd0) begin n_fail++; $display("FAIL stall_first got v%b ch%0d want v1 ch0", evt_if.evt_valid, evt_if.evt_ch); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd0) begin
        n_fail++; $display("FAIL stall_hold cyc %0d got v%b ch%0d want v1 ch0", c, evt_if.evt_valid, evt_if.evt_ch);
      end
    end
    evt_if.evt_ready = 1'b1;
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b0 || pending !== 4'b1010) begin n_fail++; $display("FAIL order_gap0 got v%b pend %b want v0 1010", evt_if.evt_valid, pending); end
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd1) begin n_fail++; $display("FAIL order_ch1 got v%b ch%0d want v1 ch1", evt_if.evt_valid, evt_if.evt_ch); end
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL order_gap1 got v%b want v0", evt_if.evt_valid); end
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd3) begin n_fail++; $display("FAIL order_ch3 got v%b ch%0d want v1 ch3", evt_if.evt_valid, evt_if.evt_ch); end
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b0 || pending !== 4'h0) begin n_fail++; $display("FAIL order_done got v%b pend %b want v0 0000", evt_if.evt_valid, pending); end
    evt_if.evt_ready = 1'b0;
    din = '1;
    repeat (3) tick();
  endtask

  task automatic test_wrap();
    evt_if.evt_ready = 1'b1;
    din[1] = 1'b0;
    repeat (4) tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd1) begin n_fail++; $display("FAIL wrap_ch1 got v%b ch%0d want v1 ch1", evt_if.evt_valid, evt_if.evt_ch); end
    tick();
    evt_if.evt_ready = 1'b0;
    din[1] = 1'b1;
    repeat (3) tick();
    din = 4'b0110;
    repeat (4) tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd3) begin n_fail++; $display("FAIL wrap_first got v%b ch%0d want v1 ch3", evt_if.evt_valid, evt_if.evt_ch); end
    evt_if.evt_ready = 1'b1;
    repeat (2) tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd0) begin n_fail++; $display("FAIL wrap_second got v%b ch%0d want v1 ch0", evt_if.evt_valid, evt_if.evt_ch); end
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b0 || pending !== 4'h0) begin n_fail++; $display("FAIL wrap_done got v%b pend %b want v0 0000", evt_if.evt_valid, pending); end
    evt_if.evt_ready = 1'b0;
    din = '1;
    repeat (3) tick();
  endtask

  task automatic test_enable_offer();
    evt_if.evt_ready = 1'b0;
    din[1] = 1'b0;
    repeat (4) tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd1) begin n_fail++; $display("FAIL en_offer got v%b ch%0d want v1 ch1", evt_if.evt_valid, evt_if.evt_ch); end
    enable[1] = 1'b0;
    tick();
    n_cmp++; if (pending !== 4'h0) begin n_fail++; $display("FAIL en_pend_clr got %b want 0000", pending); end
    n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd1) begin n_fail++; $display("FAIL en_persist got v%b ch%0d want v1 ch1", evt_if.evt_valid, evt_if.evt_ch); end
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL en_accept got v%b want v0", evt_if.evt_valid); end
    din[1] = 1'b1;
    repeat (3) tick();
    din[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (evt_if.evt_valid !== 1'b0 || pending !== 4'h0) begin
        n_fail++; $display("FAIL en_masked cyc %0d got v%b pend %b want v0 0000", c, evt_if.evt_valid, pending);
      end
    end
    din[1] = 1'b1;
    repeat (3) tick();
    enable = '1;
    tick();
  endtask

  task automatic test_repeat_edges();
    evt_if.evt_ready = 1'b0;
    din[0] = 1'b0;
    repeat (4) tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_ch !== 2'd0) begin n_fail++; $display("FAIL rep_offer got v%b ch%0d want v1 ch0", evt_if.evt_valid, evt_if.evt_ch); end
`ifdef EDGE_ARB_OVF_EN
    n_cmp++; if (ovf !== 4'h0) begin n_fail++; $display("FAIL ovf_first got %b want 0000", ovf); end
`endif
    din[0] = 1'b1;
    repeat (3) tick();
    din[0] = 1'b0;
    repeat (3) tick();
    n_cmp++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL rep_pend got %b want 0001", pending); end
`ifdef EDGE_ARB_OVF_EN
    n_cmp++; if (ovf !== 4'b0001) begin n_fail++; $display("FAIL ovf_set got %b want 0001", ovf); end
    ovf_clr = 4'b0001;
    tick();
    ovf_clr = '0;
    n_cmp++; if (ovf !== 4'h0) begin n_fail++; $display("FAIL ovf_clr got %b want 0000", ovf); end
`endif
    evt_if.evt_ready = 1'b1;
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b0 || pending !== 4'h0) begin n_fail++; $display("FAIL rep_accept got v%b pend %b want v0 0000", evt_if.evt_valid, pending); end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (evt_if.evt_valid !== 1'b0) begin
        n_fail++; $display("FAIL rep_single cyc %0d got v%b want v0", c, evt_if.evt_valid);
      end
    end
    evt_if.evt_ready = 1'b0;
    din = '1;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_reset_mid_offer();
    test_stall_order();
    test_wrap();
    test_enable_offer();
    test_repeat_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
